// File: rtl/uart_send_cfg.sv
// rtl/uart_send_cfg.sv - parametrised UART transmitter with valid/ready input; parity bit compiled in by UART_TX_PARITY_EN
module uart_send_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW      = $clog2(BPS_CNT);
    localparam int BW      = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(BPS_CNT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (BPS_CNT < 2) begin : g_bad_bps
        $error("uart_send_cfg: CLK_FREQ/UART_BPS must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_send_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_send_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_send_cfg: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift;
`ifdef UART_TX_PARITY_EN
    logic                   parity;
`endif

    logic bit_end;
    assign bit_end = (cnt == CNT_LAST);

    // uart_txd is registered, so each transition loads the level of the bit that starts next
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
            uart_txd <= 1'b1;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= bit_end ? '0 : cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift    <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity   <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        state    <= START;
                        uart_txd <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        uart_txd <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_txd <= parity;
`else
                            state    <= STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shift    <= shift >> 1;
                            uart_txd <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == STOP_LAST) begin
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                        uart_txd <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_send_cfg.sv
// tb/tb_uart_send_cfg.sv - scoreboard bench for uart_send_cfg (8-bit/1-stop and 7-bit/2-stop units, odd-parity unit when UART_TX_PARITY_EN)
module tb_uart_send_cfg;

    localparam int BPS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NDUT = 3;
    localparam int PB   = 1;
`else
    localparam int NDUT = 2;
    localparam int PB   = 0;
`endif
    localparam int DB  [3] = '{8, 7, 8};
    localparam int SB  [3] = '{1, 2, 1};
    localparam int ODD [3] = '{0, 0, 1};

    typedef struct {
        logic [8:0] data;
        bit         abort;
        bit         b2b;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tdata_a;
    logic [6:0] tdata_b;
    logic [7:0] tdata_c;
    logic       tvalid   [NDUT];
    logic       tready   [NDUT];
    logic       txd      [NDUT];
    logic       busy     [NDUT];
    logic       done     [NDUT];
    frame_t     exp_q    [NDUT][$];
    bit         in_frame [NDUT];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_send_cfg #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tdata_a), .tx_valid(tvalid[0]), .tx_ready(tready[0]),
        .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    uart_send_cfg #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tdata_b), .tx_valid(tvalid[1]), .tx_ready(tready[1]),
        .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));

`ifdef UART_TX_PARITY_EN
    uart_send_cfg #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_data(tdata_c), .tx_valid(tvalid[2]), .tx_ready(tready[2]),
        .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Line level of frame bit i: start, data LSB first, optional parity, stop bits
    function automatic logic exp_bit(input int g, input logic [8:0] d, input int i);
        logic p;
        if (i == 0) return 1'b0;
        if (i <= DB[g]) return d[i-1];
        if (PB == 1 && i == DB[g] + 1) begin
            p = (ODD[g] != 0);
            for (int j = 0; j < DB[g]; j++) p = p ^ d[j];
            return p;
        end
        return 1'b1;
    endfunction

    task automatic set_data(input int k, input logic [8:0] d);
        case (k)
            0: tdata_a = d[7:0];
            1: tdata_b = d[6:0];
            default: tdata_c = d[7:0];
        endcase
    endtask

    task automatic xfer(input int k, input logic [8:0] d, input bit ab, input bit b2b, input bit hold);
        frame_t f;
        bit seen;
        f.data = d; f.abort = ab; f.b2b = b2b;
        set_data(k, d);
        tvalid[k] = 1'b1;
        exp_q[k].push_back(f);
        seen = 0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (tready[k] === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL ready_timeout dut%0d actual=0 expected=1", k);
        end
        @(posedge clk); #1;
        if (!hold) tvalid[k] = 1'b0;
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_mon
        initial begin
            frame_t e;
            int     flen, t0, last_t0;
            bit     aborted;
            last_t0 = -1000;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) continue;
                if (txd[g] !== 1'b0) begin
                    check($sformatf("idle_done_dut%0d", g), done[g], 1'b0);
                    continue;
                end
                if (exp_q[g].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start dut%0d actual=start expected=idle", g);
                    continue;
                end
                e = exp_q[g].pop_front();
                in_frame[g] = 1;
                flen = (1 + DB[g] + PB + SB[g]) * BPS;
                t0 = cyc;
                aborted = 0;
                if (e.b2b) check($sformatf("b2b_gap_dut%0d", g), t0 - last_t0, flen + 1);
                last_t0 = t0;
                for (int c = 0; c <= flen; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1;
                        check($sformatf("abort_expected_dut%0d", g), e.abort, 1);
                        @(negedge clk);
                        check("abort_txd", txd[g], 1'b1);
                        check("abort_busy", busy[g], 1'b0);
                        check("abort_done", done[g], 1'b0);
                        check("abort_ready", tready[g], 1'b0);
                        for (int n = 0; n < 100 && rst_n !== 1'b1; n++) @(negedge clk);
                        @(negedge clk);
                        check("release_ready", tready[g], 1'b1);
                        break;
                    end
                    if (c % BPS == BPS / 2)
                        check($sformatf("bit%0d_dut%0d_data%0h", c / BPS, g, e.data), txd[g], exp_bit(g, e.data, c / BPS));
                    check($sformatf("done_c%0d_dut%0d", c, g), done[g], (c == flen));
                    if (c == flen) begin
                        check($sformatf("end_ready_dut%0d", g), tready[g], 1'b1);
                        check($sformatf("end_txd_dut%0d", g), txd[g], 1'b1);
                    end else begin
                        check($sformatf("ready_busy_c%0d_dut%0d", c, g), {30'd0, tready[g], busy[g]}, 32'd1);
                    end
                end
                if (!aborted) check($sformatf("abort_missing_dut%0d", g), e.abort, 0);
                in_frame[g] = 0;
            end
        end
    end

    initial begin
        bit drained;
        rst_n = 1'b0;
        tdata_a = '0; tdata_b = '0; tdata_c = '0;
        for (int k = 0; k < NDUT; k++) begin
            tvalid[k] = 1'b0;
            in_frame[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_txd_dut%0d", k), txd[k], 1'b1);
            check($sformatf("rst_ready_dut%0d", k), tready[k], 1'b0);
            check($sformatf("rst_busy_dut%0d", k), busy[k], 1'b0);
            check($sformatf("rst_done_dut%0d", k), done[k], 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NDUT; k++) check($sformatf("first_ready_dut%0d", k), tready[k], 1'b1);

        xfer(0, 9'h0A5, 0, 0, 0);
        xfer(1, 9'h07F, 0, 0, 0);
`ifdef UART_TX_PARITY_EN
        xfer(2, 9'h0A5, 0, 0, 0);
`endif
        xfer(0, 9'h055, 0, 0, 1);
        xfer(0, 9'h0AA, 0, 1, 0);

        xfer(0, 9'h00F, 0, 0, 0);
        repeat (25) @(posedge clk);
        #1;
        set_data(0, 9'h0F0);

        xfer(0, 9'h096, 1, 0, 0);
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(0, 9'h03C, 0, 0, 0);

        drained = 0;
        for (int n = 0; n < 5000 && !drained; n++) begin
            @(negedge clk);
            drained = 1;
            for (int k = 0; k < NDUT; k++)
                if (exp_q[k].size() != 0 || in_frame[k]) drained = 0;
        end
        if (!drained) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=pending expected=empty");
        end
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_send_cfg.md
# uart_send_cfg

Parametrised UART transmitter for the RS232 path. Generalises the fixed 8N1 sender: configurable data width and stop-bit count, optional parity, and a valid/ready handshake in place of edge-detected start pulses. It sits between the on-chip data source (FIFO or loopback logic) and the `uart_txd` pin, and reports frame completion upstream.

## Interface

**Parameters**
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `UART_BPS`, default 9600: baud rate. `BPS_CNT = CLK_FREQ/UART_BPS` (integer division) must be ≥ 2. Elaboration fails otherwise.
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame, legal values 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Meaningful only with `UART_TX_PARITY_EN`.

**Ports**
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, **synchronous, active-low**.
- `tx_data` in `DATA_BITS`: word to send. Sampled only on the accepting edge.
- `tx_valid` in 1: source has a word.
- `tx_ready` out 1: block can accept a word. Registered.
- `uart_txd` out 1: serial line, idle high, LSB first.
- `tx_busy` out 1: high from the cycle after acceptance until the frame ends.
- `tx_done` out 1: one-cycle pulse when a frame completes.

## Operation

- **States:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **Acceptance:** a transfer occurs on an edge where `tx_valid & tx_ready`. On that edge the block:
  - latches `tx_data` into a shift register,
  - moves to START,
  - clears `tx_ready`,
  - sets `tx_busy`.
- **Bit timing:** a baud counter runs 0..`BPS_CNT-1`, width `$clog2(BPS_CNT)`. Every bit lasts exactly `BPS_CNT` cycles. The counter reloads to 0 at each bit boundary and holds at 0 in IDLE.
- **START:** `uart_txd` = 0.
- **DATA:** `uart_txd` = `shift[0]`. The shift register shifts right at each bit boundary. A bit counter runs 0..`DATA_BITS-1`; DATA exits after bit `DATA_BITS-1`.
- **PARITY** (only if enabled): `uart_txd` = XOR of latched data for even parity, its inverse for odd.
- **STOP:** `uart_txd` = 1 for `STOP_BITS` bit periods.
- **Frame end:** at the last cycle of the final stop bit, the next edge:
  - moves to IDLE,
  - sets `tx_ready` = 1,
  - clears `tx_busy`,
  - pulses `tx_done` for one cycle.
- **In-frame inputs:** `tx_valid` and `tx_data` changes during a frame are ignored.
- **Reset:** with `rst_n` low at an edge, the block goes to IDLE regardless of state, and all counters and the shift register clear. A frame in progress is aborted with no `tx_done`.
- **Reset values:**
  - `uart_txd` = 1
  - `tx_ready` = 0
  - `tx_busy` = 0
  - `tx_done` = 0
- **After reset release:** `tx_ready` rises on the first edge with `rst_n` high.

## Timing

- **Latency:** `uart_txd` falls in the cycle immediately after the accepting edge.
- **Frame length:** `F = BPS_CNT*(1+DATA_BITS+P+STOP_BITS)` cycles, where P = 1 with parity enabled, else 0.
- **`tx_done`:** high during cycle `F` after acceptance, numbering the first START cycle as 0. This is the same cycle `tx_ready` returns high.
- **Back-to-back frames:** with `tx_valid` held high, the next word is accepted on the edge ending that cycle. The line stays high for exactly one extra cycle between frames, so start-bit falling edges are `F+1` cycles apart.
- **`tx_ready`:** never high while `tx_busy` is high.

## Configuration

- **`UART_TX_PARITY_EN` defined:** PARITY state compiled in. One parity bit follows the data, polarity set by `PARITY_ODD`.
- **`UART_TX_PARITY_EN` undefined:** no PARITY state or parity logic. The frame goes DATA → STOP, and `PARITY_ODD` is ignored.

## Test plan

All scenarios use `CLK_FREQ`=50000000, `UART_BPS`=5000000, giving `BPS_CNT`=10.

- **8N1, 0xA5:** accept 0xA5 → `uart_txd` per 10-cycle bit is 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses at cycle 100 with `tx_ready`=1 in the same cycle.
- **Parity enabled, 0xA5:** macro defined, 0xA5 sent once with `PARITY_ODD`=0 and once with 1 → parity bit 0 then 1 (bit 9, cycles 90–99), stop bit at 100–109, `tx_done` at cycle 110.
- **Back-to-back:** 0x55 then 0xAA with `tx_valid` held high → the two start-bit falling edges are 101 cycles apart. Second frame reads 0,0,1,0,1,0,1,0,1,1.
- **7 data bits, 2 stop bits, 0x7F:** `DATA_BITS`=7, `STOP_BITS`=2 → 0, then seven 1s, then 1,1. Frame is 100 cycles and `tx_done` fires once.
- **Reset mid-frame:** `rst_n` low at cycle 40 of a frame → `uart_txd`=1 and `tx_busy`=0 after that edge, no `tx_done`. `tx_ready`=1 one edge after release, and a new 0x3C frame is correct.
- **Data stability:** change `tx_data` from 0x0F to 0xF0 at cycle 25 of a frame → the transmitted bits still match 0x0F.
